// File: rtl/pe_dense_pkg.sv
// Shared types and helpers for the dense-layer sequencer.
// Optional BIAS phase is enabled by the PE_DENSE_SEQ_BIAS_EN macro.
package pe_dense_pkg;

    localparam int DENSE_VALID_W = 8;
    localparam int LANE_MAX      = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        BIAS,
        LATCH,
        DRAIN,
        FIN
    } dense_state_t;

    // Low `lanes` bits set.
    function automatic logic [LANE_MAX-1:0] lane_mask(input logic [DENSE_VALID_W-1:0] lanes);
        logic [LANE_MAX-1:0] m;
        for (int i = 0; i < LANE_MAX; i++) begin
            m[i] = (i < int'(lanes));
        end
        return m;
    endfunction

endpackage

// File: rtl/pe_dense_seq_drain_cnt.sv
// Drain-phase read-address counter: ready/valid handshake with last-lane detect.
module pe_dense_drain_cnt
    import pe_dense_pkg::*;
#(
    parameter int LOG_N_PE = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic                i_ready,
    input  logic [LOG_N_PE-1:0] i_last_idx,
    output logic [LOG_N_PE-1:0] o_rd_addr,
    output logic                o_valid,
    output logic                o_last
);

    logic [LOG_N_PE-1:0] r_addr;
    logic                w_fire;

    assign w_fire    = i_en & i_ready;
    assign o_valid   = i_en;
    assign o_last    = w_fire && (r_addr == i_last_idx);
    assign o_rd_addr = r_addr;

    // Returns to lane 0 after the last beat so the next group starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (i_clr || o_last) begin
            r_addr <= '0;
        end else if (w_fire) begin
            r_addr <= r_addr + 1'b1;
        end
    end

endmodule

// File: rtl/pe_dense_seq.sv
// Dense-layer sequencer: splits a layer into N_PE-lane groups and runs clear/accumulate/latch/drain.
// Define PE_DENSE_SEQ_BIAS_EN to insert a one-cycle BIAS phase before LATCH (adds bias_enable).
module pe_dense_seq
    import pe_dense_pkg::*;
#(
    parameter int N_PE     = 8,
    parameter int LOG_N_PE = 3,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         num_inputs,
    input  logic [CNT_W-1:0]         num_outputs,
    input  logic                     in_valid,
    input  logic                     out_ready,
    output logic                     dense_enable,
    output logic [N_PE-1:0]          dense_adder_reset,
    output logic [N_PE-1:0]          dense_adder_on,
    output logic                     dense_latch,
    output logic [LOG_N_PE-1:0]      dense_rd_addr,
    output logic [DENSE_VALID_W-1:0] dense_valid,
    output logic                     out_valid,
    output logic                     in_ready,
    output logic                     busy,
`ifdef PE_DENSE_SEQ_BIAS_EN
    output logic [N_PE-1:0]          bias_enable,
`endif
    output logic                     done
);

`ifdef PE_DENSE_SEQ_BIAS_EN
    localparam dense_state_t ACC_NEXT = BIAS;
`else
    localparam dense_state_t ACC_NEXT = LATCH;
`endif

    dense_state_t            r_state, w_next;
    logic [CNT_W-1:0]        r_num_in;
    logic [CNT_W-1:0]        r_rem;
    logic [CNT_W-1:0]        r_beat;
    logic [DENSE_VALID_W-1:0] r_lanes;

    logic [CNT_W-1:0]         w_beat_inc;
    logic [CNT_W-1:0]         w_rem_dec;
    logic [CNT_W-1:0]         w_lanes_src;
    logic [DENSE_VALID_W-1:0] w_lanes_new;
    logic [LANE_MAX-1:0]      w_mask_full;
    logic [N_PE-1:0]          w_mask;
    logic [LOG_N_PE-1:0]      w_last_idx;
    logic                     w_last;
    logic                     w_start_ok;

    assign w_start_ok  = (r_state == IDLE) && start;
    assign w_beat_inc  = r_beat + 1'b1;
    assign w_rem_dec   = r_rem - CNT_W'(r_lanes);
    // Group size comes from the fresh config on start, else from what remains after this group.
    assign w_lanes_src = (r_state == IDLE) ? num_outputs : w_rem_dec;
    assign w_lanes_new = (w_lanes_src < CNT_W'(N_PE)) ? w_lanes_src[DENSE_VALID_W-1:0]
                                                       : DENSE_VALID_W'(N_PE);
    assign w_mask_full = lane_mask(r_lanes);
    assign w_mask      = w_mask_full[N_PE-1:0];
    assign w_last_idx  = LOG_N_PE'(r_lanes - DENSE_VALID_W'(1));

    pe_dense_drain_cnt #(
        .LOG_N_PE (LOG_N_PE)
    ) u_drain (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (r_state == LATCH),
        .i_en       (r_state == DRAIN),
        .i_ready    (out_ready),
        .i_last_idx (w_last_idx),
        .o_rd_addr  (dense_rd_addr),
        .o_valid    (out_valid),
        .o_last     (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (num_outputs != '0) ? CLEAR : FIN;
            CLEAR:   w_next = (r_num_in == '0) ? ACC_NEXT : ACCUM;
            ACCUM:   if (in_valid && (w_beat_inc == r_num_in)) w_next = ACC_NEXT;
            BIAS:    w_next = LATCH;
            LATCH:   w_next = DRAIN;
            DRAIN:   if (w_last) w_next = (w_rem_dec != '0) ? CLEAR : FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num_in <= '0;
            r_rem    <= '0;
            r_beat   <= '0;
            r_lanes  <= '0;
        end else begin
            if (w_start_ok) begin
                r_num_in <= num_inputs;
                r_rem    <= num_outputs;
            end else if ((r_state == DRAIN) && w_last) begin
                r_rem <= w_rem_dec;
            end
            if (w_start_ok || ((r_state == DRAIN) && w_last)) begin
                r_lanes <= w_lanes_new;
            end
            if (r_state == CLEAR) begin
                r_beat <= '0;
            end else if ((r_state == ACCUM) && in_valid) begin
                r_beat <= w_beat_inc;
            end
        end
    end

    always_comb begin
        dense_adder_reset = '0;
        dense_adder_on    = '0;
        dense_latch       = 1'b0;
        in_ready          = 1'b0;
        done              = 1'b0;
        case (r_state)
            CLEAR: dense_adder_reset = w_mask;
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) dense_adder_on = w_mask;
            end
            LATCH:   dense_latch = 1'b1;
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

`ifdef PE_DENSE_SEQ_BIAS_EN
    assign bias_enable = (r_state == BIAS) ? w_mask : '0;
`endif

    assign busy         = (r_state != IDLE);
    assign dense_enable = busy;
    assign dense_valid  = r_lanes;

endmodule

// File: tb/tb_pe_dense_seq.sv
// Directed self-checking bench for pe_dense_seq (honours PE_DENSE_SEQ_BIAS_EN when defined).
module tb_pe_dense_seq;

`ifdef PE_DENSE_SEQ_BIAS_EN
    localparam int B = 1;
`else
    localparam int B = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_inputs;
    logic [15:0] num_outputs;
    logic        in_valid;
    logic        out_ready;
    logic        dense_enable;
    logic [7:0]  dense_adder_reset;
    logic [7:0]  dense_adder_on;
    logic        dense_latch;
    logic [2:0]  dense_rd_addr;
    logic [7:0]  dense_valid;
    logic        out_valid;
    logic        in_ready;
    logic        busy;
    logic        done;
`ifdef PE_DENSE_SEQ_BIAS_EN
    logic [7:0]  bias_enable;
`endif

    pe_dense_seq dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .num_inputs        (num_inputs),
        .num_outputs       (num_outputs),
        .in_valid          (in_valid),
        .out_ready         (out_ready),
        .dense_enable      (dense_enable),
        .dense_adder_reset (dense_adder_reset),
        .dense_adder_on    (dense_adder_on),
        .dense_latch       (dense_latch),
        .dense_rd_addr     (dense_rd_addr),
        .dense_valid       (dense_valid),
        .out_valid         (out_valid),
        .in_ready          (in_ready),
        .busy              (busy),
`ifdef PE_DENSE_SEQ_BIAS_EN
        .bias_enable       (bias_enable),
`endif
        .done              (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc, n_clr, n_on, n_latch, n_beats, n_done, last_on, latch_cyc, done_cyc, act;
    int stall_left, stall_seen, stall_bad;
    bit tog, stall_armed;
    logic [7:0] clr_mask [4];
    logic [7:0] clr_dv   [4];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {31'd0, dense_enable, dense_adder_reset, dense_adder_on, dense_latch,
                dense_rd_addr, dense_valid, out_valid, in_ready, busy, done};
    endfunction

    task automatic clear_counts();
        cyc = 0; n_clr = 0; n_on = 0; n_latch = 0; n_beats = 0; n_done = 0;
        last_on = -1; latch_cyc = -1; done_cyc = -1; act = 0;
        stall_left = 0; stall_seen = 0; stall_bad = 0;
        for (int i = 0; i < 4; i++) begin
            clr_mask[i] = '0;
            clr_dv[i]   = '0;
        end
    endtask

    // Called just after a falling edge: presents config with a start pulse for cycle 0.
    task automatic begin_layer(input int ni, input int no);
        clear_counts();
        num_inputs  = 16'(ni);
        num_outputs = 16'(no);
        start       = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
        if (tog) in_valid = ~in_valid;
        if (stall_armed && out_valid && dense_rd_addr == 3'd2) begin
            out_ready   = 1'b0;
            stall_left  = 5;
            stall_armed = 1'b0;
        end else if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) out_ready = 1'b1;
        end
        @(negedge clk);
        cyc++;
        if (dense_adder_reset != '0) begin
            if (n_clr < 4) begin
                clr_mask[n_clr] = dense_adder_reset;
                clr_dv[n_clr]   = dense_valid;
            end
            n_clr++;
        end
        if (dense_adder_on != '0) begin
            n_on++;
            last_on = cyc;
        end
        if (dense_latch) begin
            n_latch++;
            latch_cyc = cyc;
        end
        if (out_valid && out_ready) n_beats++;
        if (out_valid && !out_ready) begin
            stall_seen++;
            if (dense_rd_addr != 3'd2) stall_bad++;
        end
        if (out_valid || in_ready || dense_latch || dense_adder_reset != '0) act++;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic run_to_done(input string tag, input int bound);
        int k = 0;
        while (n_done == 0 && k < bound) begin
            step();
            k++;
        end
        if (n_done == 0) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_v;
        rst = 1'b1; start = 1'b0; num_inputs = '0; num_outputs = '0;
        in_valid = 1'b0; out_ready = 1'b0; tog = 1'b0; stall_armed = 1'b0;
        clear_counts();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outs", all_outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // One full group of 8 lanes, 4 inputs, no back-pressure.
        begin_layer(4, 8);
        in_valid = 1'b1; out_ready = 1'b1;
        check_eq("t1_c0_idle", {63'd0, busy}, 64'd0);
        for (int k = 1; k <= 16 + B; k++) begin
            step();
            exp_v = 64'd0;
            exp_v[20]    = (k == 1);                         // any adder_reset
            exp_v[19]    = (k >= 2 && k <= 5);               // any adder_on
            exp_v[18]    = (k == 6 + B);                     // latch
            exp_v[17]    = (k >= 7 + B && k <= 14 + B);      // out_valid
            exp_v[16:14] = (k >= 7 + B && k <= 14 + B) ? 3'(k - 7 - B) : 3'd0;
            exp_v[13]    = (k == 15 + B);                    // done
            exp_v[12]    = (k <= 15 + B);                    // busy
            check_eq($sformatf("t1_c%0d", k),
                     {43'd0, (dense_adder_reset == 8'hFF), (dense_adder_on == 8'hFF), dense_latch,
                      out_valid, dense_rd_addr, done, busy, 12'd0},
                     exp_v);
            if (k <= 14 + B) check_eq($sformatf("t1_dv%0d", k), {56'd0, dense_valid}, 64'd8);
        end

        // Two groups: 8 lanes then 3.
        begin_layer(2, 11);
        run_to_done("t2", 200);
        check_eq("t2_groups", n_clr, 2);
        check_eq("t2_mask0", clr_mask[0], 8'hFF);
        check_eq("t2_mask1", clr_mask[1], 8'h07);
        check_eq("t2_dv0", clr_dv[0], 8'd8);
        check_eq("t2_dv1", clr_dv[1], 8'd3);
        check_eq("t2_beats", n_beats, 11);
        check_eq("t2_on", n_on, 4);
        check_eq("t2_latch", n_latch, 2);
        check_eq("t2_done", n_done, 1);

        // Toggling in_valid: only valid beats accumulate.
        begin_layer(3, 2);
        in_valid = 1'b1; tog = 1'b1;
        run_to_done("t3", 200);
        tog = 1'b0; in_valid = 1'b1;
        check_eq("t3_on", n_on, 3);
        check_eq("t3_latch_lat", latch_cyc - last_on, 1 + B);
        check_eq("t3_beats", n_beats, 2);

        // Back-pressure during drain at lane 2.
        begin_layer(1, 4);
        stall_armed = 1'b1;
        run_to_done("t4", 200);
        check_eq("t4_stall_hit", {63'd0, stall_armed}, 64'd0);
        check_eq("t4_stall_cycles", stall_seen, 5);
        check_eq("t4_stall_addr", stall_bad, 0);
        check_eq("t4_beats", n_beats, 4);
        check_eq("t4_done", n_done, 1);

        // Zero outputs: done one cycle after start, nothing else.
        begin_layer(5, 0);
        repeat (4) step();
        check_eq("t5_done_cyc", done_cyc, 1);
        check_eq("t5_done_cnt", n_done, 1);
        check_eq("t5_activity", act, 0);
        check_eq("t5_dv", {56'd0, dense_valid}, 64'd0);

        // Zero inputs: CLEAR straight to LATCH.
        begin_layer(0, 3);
        run_to_done("t6", 100);
        check_eq("t6_latch_cyc", latch_cyc, 2 + B);
        check_eq("t6_on", n_on, 0);
        check_eq("t6_mask", clr_mask[0], 8'h07);
        check_eq("t6_beats", n_beats, 3);

        // Reset in the middle of ACCUM, then a clean layer.
        begin_layer(10, 8);
        in_valid = 1'b1;
        repeat (3) step();
        check_eq("t7_in_accum", {63'd0, in_ready}, 64'd1);
        rst = 1'b1;
        #1;
        check_eq("t7_rst_outs", all_outs(), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        clear_counts();
        repeat (5) step();
        check_eq("t7_no_done", n_done, 0);
        check_eq("t7_idle", {63'd0, busy}, 64'd0);
        begin_layer(1, 2);
        run_to_done("t7b", 100);
        check_eq("t7b_done", n_done, 1);
        check_eq("t7b_beats", n_beats, 2);
        check_eq("t7b_mask", clr_mask[0], 8'h03);
        check_eq("t7b_dv", clr_dv[0], 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
